// File: rtl/ring_nic_pkg.sv
// +--------------------------------------------------------------------------+
// | ring_nic_pkg : shared constants for the gold-ring NIC                      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

package ring_nic_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 2;

  localparam logic [0:ADDR_W-1] IN_BUF     = 2'b00;
  localparam logic [0:ADDR_W-1] IN_STATUS  = 2'b01;
  localparam logic [0:ADDR_W-1] OUT_BUF    = 2'b10;
  localparam logic [0:ADDR_W-1] OUT_STATUS = 2'b11;

  // Packet fields, MSB-first numbering; only the VC bit is ever interpreted.
  localparam int VC_BIT  = 0;
  localparam int DIR_BIT = 1;
  localparam int RSVD_LO = 2;
  localparam int RSVD_HI = 7;
  localparam int HOP_LO  = 8;
  localparam int HOP_HI  = 15;
  localparam int SRC_LO  = 16;
  localparam int SRC_HI  = 31;
  localparam int PAY_LO  = 32;
  localparam int PAY_HI  = 63;

  function automatic logic pkt_vc(input logic [0:DATA_W-1] pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

`default_nettype wire

// File: rtl/nic_slot.sv
// +--------------------------------------------------------------------------+
// | nic_slot : one-packet buffer with full flag, load port and clear port      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module nic_slot #(
  parameter int SLOT_W = ring_nic_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [0:SLOT_W-1] i_wr_data,
  input  logic              i_clr,
  output logic              o_full,
  output logic [0:SLOT_W-1] o_data
);

  import ring_nic_pkg::*;

  logic              r_full;
  logic [0:SLOT_W-1] r_data;

  // The clear only drops the flag; the stale word stays readable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_wr_en) begin
      r_full <= 1'b1;
      r_data <= i_wr_data;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/ring_nic.sv
// +--------------------------------------------------------------------------+
// | ring_nic : PE <-> gold-ring port interface with one-packet in/out buffers  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module ring_nic #(
  parameter int DATA_W = ring_nic_pkg::DATA_W,
  parameter int ADDR_W = ring_nic_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:ADDR_W-1] addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
);

  import ring_nic_pkg::*;

  logic              w_in_full;
  logic              w_out_full;
  logic [0:DATA_W-1] w_in_buf;
  logic [0:DATA_W-1] w_out_buf;
  logic              w_pe_rd;
  logic              w_pe_wr;
  logic              w_out_load;
  logic              w_send;
  logic              w_in_load;
  logic              w_in_pop;
  logic [0:DATA_W-1] r_d_out;

  assign w_pe_rd    = nicEn & ~nicWrEn;
  assign w_pe_wr    = nicEn & nicWrEn & (addr == OUT_BUF);
  assign w_out_load = w_pe_wr & ~w_out_full;
  assign w_send     = w_out_full & net_ro & (pkt_vc(w_out_buf) == net_polarity);

  // Loads only into an empty slot, so a pop and a load never coincide.
  assign w_in_load  = net_si & ~w_in_full;
  assign w_in_pop   = w_pe_rd & (addr == IN_BUF) & w_in_full;

  nic_slot #(.SLOT_W(DATA_W)) u_in_slot (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_in_load),
    .i_wr_data (net_di),
    .i_clr     (w_in_pop),
    .o_full    (w_in_full),
    .o_data    (w_in_buf)
  );

  nic_slot #(.SLOT_W(DATA_W)) u_out_slot (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_out_load),
    .i_wr_data (d_in),
    .i_clr     (w_send),
    .o_full    (w_out_full),
    .o_data    (w_out_buf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_out <= '0;
    end else if (w_pe_rd) begin
      case (addr)
        IN_BUF:     r_d_out <= w_in_buf;
        IN_STATUS:  r_d_out <= {{(DATA_W-1){1'b0}}, w_in_full};
        OUT_STATUS: r_d_out <= {{(DATA_W-1){1'b0}}, w_out_full};
        default:    r_d_out <= r_d_out;
      endcase
    end
  end

  assign d_out  = r_d_out;
  assign net_do = w_out_buf;
  assign net_so = w_send;
  assign net_ri = ~w_in_full;

endmodule

`default_nettype wire

// File: tb/tb_ring_nic.sv
// +--------------------------------------------------------------------------+
// | tb_ring_nic : directed vector table, async-reset sequence, random vs model |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ring_nic;

  localparam logic [63:0] W1 = 64'h8001_0000_0000_0003;
  localparam logic [63:0] W2 = 64'h0000_0001_0000_0002;
  localparam logic [63:0] W3 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] W4 = 64'h0001_0002_0000_0044;
  localparam logic [63:0] W5 = 64'h8000_0000_0000_0055;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in, d_out, net_do, net_di;
  logic        nicEn, nicWrEn, net_so, net_ro, net_polarity, net_si, net_ri;

  int total = 0;
  int bad   = 0;

  logic [0:63] in_q[$];
  logic [0:63] out_q[$];
  logic [0:63] m_in_last, m_out_last, m_dout;

  typedef struct {
    logic        en, wr;
    logic [1:0]  a;
    logic [63:0] din;
    logic        ro, si;
    logic [63:0] di;
    logic        pol;
    logic        so, ri;
    logic [63:0] dout_e, do_e;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  ring_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input logic [1:0] a,
                       input logic [63:0] din, input logic ro, input logic si,
                       input logic [63:0] di, input logic pol);
    @(negedge clk);
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_ro = ro; net_si = si; net_di = di; net_polarity = pol;
  endtask

  task automatic model_reset();
    in_q.delete();
    out_q.delete();
    m_in_last = '0; m_out_last = '0; m_dout = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'd1, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0};
    tbl[1]  = '{1'b1, 1'b0, 2'd3, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd0, 64'd0};
    tbl[2]  = '{1'b1, 1'b1, 2'd2, W1,    1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd0, 64'd0};
    tbl[3]  = '{1'b1, 1'b0, 2'd3, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd1, W1};
    tbl[4]  = '{1'b1, 1'b1, 2'd2, W3,    1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd1, W1};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd1, W1};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 64'd1, W1};
    tbl[7]  = '{1'b1, 1'b0, 2'd3, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd0, W1};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 1'b1, W2,    1'b1, 1'b0, 1'b1, 64'd0, W1};
    tbl[9]  = '{1'b1, 1'b0, 2'd1, 64'd0, 1'b0, 1'b1, W3,    1'b0, 1'b0, 1'b0, 64'd1, W1};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, W2,    W1};
    tbl[11] = '{1'b1, 1'b0, 2'd1, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd0, W1};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, W2,    W1};

    reset = 1'b0;
    nicEn = 0; nicWrEn = 0; addr = 0; d_in = '0;
    net_ro = 0; net_si = 0; net_di = '0; net_polarity = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_dout", d_out, 64'd0);
    chk("reset_so", {63'd0, net_so}, 64'd0);
    chk("reset_ri", {63'd0, net_ri}, 64'd1);

    // Directed vectors: inputs for one cycle, combinational outputs before the edge,
    // d_out after it.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].en, tbl[i].wr, tbl[i].a, tbl[i].din, tbl[i].ro, tbl[i].si,
            tbl[i].di, tbl[i].pol);
      #1;
      chk($sformatf("vec%0d_so", i), {63'd0, net_so}, {63'd0, tbl[i].so});
      chk($sformatf("vec%0d_ri", i), {63'd0, net_ri}, {63'd0, tbl[i].ri});
      chk($sformatf("vec%0d_do", i), net_do, tbl[i].do_e);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_dout", i), d_out, tbl[i].dout_e);
    end

    // Async reset with both buffers full: flags must clear between clock edges.
    drive(1'b1, 1'b1, 2'd2, W4, 1'b0, 1'b1, W5, 1'b1);
    @(posedge clk); #1;
    nicEn = 0; net_si = 0;
    chk("ar_full_ri", {63'd0, net_ri}, 64'd0);
    chk("ar_full_do", net_do, W4);
    #1;
    net_ro = 1; net_polarity = 0;
    #1;
    chk("ar_pre_so", {63'd0, net_so}, 64'd1);
    chk("ar_pre_dout", d_out, W2);
    reset = 1'b0;
    #1;
    chk("ar_so", {63'd0, net_so}, 64'd0);
    chk("ar_ri", {63'd0, net_ri}, 64'd1);
    chk("ar_dout", d_out, 64'd0);
    chk("ar_do", net_do, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Random traffic against the queue-based reference model.
    begin
      logic        pol = 1'b0;
      logic        en, wr, ro, si, e_so;
      logic [1:0]  a;
      logic [63:0] din, di;
      int          pre_in, pre_out;
      for (int n = 0; n < 600; n++) begin
        en  = ($urandom_range(0, 9) < 7);
        wr  = $urandom_range(0, 1) == 1;
        a   = 2'($urandom_range(0, 3));
        din = {$urandom(), $urandom()};
        ro  = $urandom_range(0, 1) == 1;
        si  = ($urandom_range(0, 9) < 3);
        di  = {$urandom(), $urandom()};
        pol = ~pol;
        drive(en, wr, a, din, ro, si, di, pol);
        #1;
        pre_in  = in_q.size();
        pre_out = out_q.size();
        e_so = (pre_out != 0) && ro && (out_q[0][0] == pol);
        chk("rnd_so", {63'd0, net_so}, {63'd0, e_so});
        chk("rnd_ri", {63'd0, net_ri}, {63'd0, (pre_in == 0)});
        chk("rnd_do", net_do, m_out_last);
        @(posedge clk); #1;
        if (en && !wr) begin
          case (a)
            2'd0: begin
              m_dout = m_in_last;
              if (pre_in != 0) void'(in_q.pop_front());
            end
            2'd1: m_dout = 64'(pre_in);
            2'd3: m_dout = 64'(pre_out);
            default: ;
          endcase
        end
        if (en && wr && a == 2'd2 && pre_out == 0) begin
          out_q.push_back(din);
          m_out_last = din;
        end
        if (e_so) void'(out_q.pop_front());
        if (si && pre_in == 0) begin
          in_q.push_back(di);
          m_in_last = di;
        end
        chk("rnd_dout", d_out, m_dout);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
